// File: rtl/lcd_sink_if.sv
// Parallel character-LCD bus between lcd_unit (master) and lcd_sink (slave).
// LCD_READBACK_EN adds the lcd_rdata return path for RW=1 strobes.
interface lcd_sink_if;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;
`ifdef LCD_READBACK_EN
    logic [7:0] lcd_rdata;

    modport master (output lcd_data, output lcd_ctrl, output lcd_enable, input lcd_rdata);
    modport slave  (input lcd_data, input lcd_ctrl, input lcd_enable, output lcd_rdata);
`else
    modport master (output lcd_data, output lcd_ctrl, output lcd_enable);
    modport slave  (input lcd_data, input lcd_ctrl, input lcd_enable);
`endif
endinterface

// File: rtl/lcd_sink.sv
// HD44780-style responder: 2x16 DDRAM, cursor/display flags and busy timing.
// Optional LCD_READBACK_EN enables RW=1 status and data reads over the bus.
module lcd_sink #(
    parameter int OP_CYCLES   = 37,
    parameter int HOME_CYCLES = 1520,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    lcd_sink_if.slave  bus,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor,
    output logic       display_on,
    output logic       cursor_on,
    output logic       busy,
    output logic       overrun,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_WAIT = 2'd2} state_t;

    state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [4:0] fill_idx, fill_idx_n;
    logic       fill_wait, fill_wait_n;
    logic [4:0] cursor_n, step;
    logic       inc, inc_n;
    logic       display_on_n, cursor_on_n, overrun_n;
    logic       en_q;
    logic [7:0] data_q;
    logic [1:0] ctrl_q;
    logic       fall, rs, rw;
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic [7:0] ddram [32];

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
    assign fall      = en_q && !bus.lcd_enable;
    assign rs        = ctrl_q[0];
    assign rw        = ctrl_q[1];
    assign step      = inc ? cursor + 5'd1 : cursor - 5'd1;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        fill_idx_n   = fill_idx;
        fill_wait_n  = fill_wait;
        cursor_n     = cursor;
        inc_n        = inc;
        display_on_n = display_on;
        cursor_on_n  = cursor_on;
        overrun_n    = overrun;
        we           = 1'b0;
        waddr        = cursor;
        wdata        = data_q;

        case (state)
            S_FILL: begin
                we         = 1'b1;
                waddr      = fill_idx;
                wdata      = 8'h20;
                fill_idx_n = fill_idx + 5'd1;
                if (fill_idx == 5'd31) begin
                    fill_wait_n = 1'b0;
                    if (fill_wait) begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_W'(HOME_CYCLES);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1)) state_n = S_IDLE;
                else                  cnt_n   = cnt - CNT_W'(1);
            end
            default: ;
        endcase

        // Accepted strobes only happen in IDLE, so they never collide with the fill writes.
        if (fall) begin
            if (!rw) begin
                if (busy) begin
                    overrun_n = 1'b1;
                end else if (rs) begin
                    we       = 1'b1;
                    cursor_n = step;
                    state_n  = S_WAIT;
                    cnt_n    = CNT_W'(OP_CYCLES);
                end else begin
                    state_n = S_WAIT;
                    cnt_n   = CNT_W'(OP_CYCLES);
                    casez (data_q)
                        8'b1???????: cursor_n = {data_q[6], data_q[3:0]};
                        8'b01??????, 8'b001?????: ;
                        8'b0001????: begin
                            if (!data_q[3]) cursor_n = data_q[2] ? cursor + 5'd1 : cursor - 5'd1;
                        end
                        8'b00001???: begin
                            display_on_n = data_q[2];
                            cursor_on_n  = data_q[1];
                        end
                        8'b000001??: inc_n = data_q[1];
                        8'b0000001?: begin
                            cursor_n = 5'd0;
                            cnt_n    = CNT_W'(HOME_CYCLES);
                        end
                        8'b00000001: begin
                            cursor_n    = 5'd0;
                            inc_n       = 1'b1;
                            state_n     = S_FILL;
                            fill_idx_n  = 5'd0;
                            fill_wait_n = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
`ifdef LCD_READBACK_EN
            else if (rs) begin
                if (busy) begin
                    overrun_n = 1'b1;
                end else begin
                    cursor_n = step;
                    state_n  = S_WAIT;
                    cnt_n    = CNT_W'(OP_CYCLES);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FILL;
            cnt        <= '0;
            fill_idx   <= 5'd0;
            fill_wait  <= 1'b0;
            cursor     <= 5'd0;
            inc        <= 1'b1;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            overrun    <= 1'b0;
            en_q       <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
            rd_data    <= 8'h00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            fill_idx   <= fill_idx_n;
            fill_wait  <= fill_wait_n;
            cursor     <= cursor_n;
            inc        <= inc_n;
            display_on <= display_on_n;
            cursor_on  <= cursor_on_n;
            overrun    <= overrun_n;
            en_q       <= bus.lcd_enable;
            rd_data    <= ddram[rd_addr];
            if (bus.lcd_enable) begin
                data_q <= bus.lcd_data;
                ctrl_q <= bus.lcd_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) ddram[waddr] <= wdata;
    end

`ifdef LCD_READBACK_EN
    always_comb begin
        bus.lcd_rdata = 8'h00;
        if (bus.lcd_enable && bus.lcd_ctrl[1]) begin
            if (!bus.lcd_ctrl[0]) bus.lcd_rdata = {busy, 2'b00, cursor};
            else if (!busy)       bus.lcd_rdata = ddram[cursor];
        end
    end
`endif
endmodule

// File: tb/tb_lcd_sink.sv
// Directed bench for lcd_sink: reset fill, writes, wrap, overrun, clear, display flags.
module tb_lcd_sink;
    localparam int OP   = 37;
    localparam int HOME = 1520;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       display_on, cursor_on, busy, overrun;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         passes = 0;
    int         n;
    int         hi;

    lcd_sink_if bus();

    lcd_sink #(.OP_CYCLES(OP), .HOME_CYCLES(HOME), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor     (cursor),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .busy       (busy),
        .overrun    (overrun),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic strobe(input logic [1:0] c, input logic [7:0] d);
        bus.lcd_ctrl   = c;
        bus.lcd_data   = d;
        bus.lcd_enable = 1'b1;
        tick();
        tick();
        bus.lcd_enable = 1'b0;
        bus.lcd_data   = 8'h00;
        bus.lcd_ctrl   = 2'b00;
        tick();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 4000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_cell(input int a, input logic [7:0] exp);
        rd_addr = 5'(a);
        tick();
        check($sformatf("cell[%0d]", a), {24'h0, rd_data}, {24'h0, exp});
    endtask

    initial begin
        rst_n          = 1'b0;
        rd_addr        = 5'd0;
        bus.lcd_data   = 8'h00;
        bus.lcd_ctrl   = 2'b00;
        bus.lcd_enable = 1'b0;
        tick(); tick(); tick();

        check("rst_busy", busy, 1);
        check("rst_cursor", cursor, 0);
        check("rst_display_on", display_on, 0);
        check("rst_cursor_on", cursor_on, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_state", state_dbg, 1);

        // Busy must cover exactly the 32 fill cycles after release.
        rst_n = 1'b1;
        hi = busy ? 1 : 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            hi += busy ? 1 : 0;
        end
        check("fill_busy_cycles", hi, 32);
        check("fill_done_busy", busy, 0);
        for (int i = 0; i < 32; i++) check_cell(i, 8'h20);

        strobe(2'b01, 8'h48);
        check("wr0_busy", busy, 1);
        wait_idle(n);
        check("wr0_busy_len", n, OP);
        strobe(2'b01, 8'h49);
        wait_idle(n);
        check("wr1_busy_len", n, OP);
        check("wr_cursor", cursor, 2);
        check_cell(0, 8'h48);
        check_cell(1, 8'h49);

        strobe(2'b00, 8'hCF);
        wait_idle(n);
        check("setaddr_cursor", cursor, 31);
        check("setaddr_busy_len", n, OP);
        strobe(2'b01, 8'h41);
        wait_idle(n);
        strobe(2'b01, 8'h42);
        wait_idle(n);
        check_cell(31, 8'h41);
        check_cell(0, 8'h42);
        check("wrap_cursor", cursor, 1);

        strobe(2'b00, 8'h04);
        wait_idle(n);
        strobe(2'b00, 8'h80);
        wait_idle(n);
        check("addr80_cursor", cursor, 0);
        strobe(2'b01, 8'h5A);
        wait_idle(n);
        check_cell(0, 8'h5A);
        check("dec_cursor", cursor, 31);

        strobe(2'b01, 8'h33);
        tick(); tick();
        check("ovr_before", overrun, 0);
        strobe(2'b01, 8'h77);
        check("ovr_set", overrun, 1);
        wait_idle(n);
        check("ovr_cursor", cursor, 30);
        check_cell(31, 8'h33);
        check_cell(30, 8'h20);

        strobe(2'b00, 8'h01);
        check("clr_state_fill", state_dbg, 1);
        check("clr_cursor", cursor, 0);
        wait_idle(n);
        check("clr_busy_len", n, 32 + HOME);
        for (int i = 0; i < 32; i++) check_cell(i, 8'h20);
        check("clr_overrun_sticky", overrun, 1);

        strobe(2'b01, 8'h11);
        wait_idle(n);
        check("clr_inc_restored", cursor, 1);
        check_cell(0, 8'h11);

        strobe(2'b00, 8'h02);
        check("home_cursor", cursor, 0);
        wait_idle(n);
        check("home_busy_len", n, HOME);
        strobe(2'b00, 8'h10);
        wait_idle(n);
        check("shift_left_wrap", cursor, 31);
        strobe(2'b00, 8'h14);
        wait_idle(n);
        check("shift_right_wrap", cursor, 0);
        strobe(2'b00, 8'h1C);
        wait_idle(n);
        check("display_shift_noop", cursor, 0);

        strobe(2'b00, 8'h0E);
        wait_idle(n);
        check("disp_on", display_on, 1);
        check("curs_on", cursor_on, 1);
        strobe(2'b00, 8'h08);
        wait_idle(n);
        check("disp_off", display_on, 0);
        check("curs_off", cursor_on, 0);

`ifndef LCD_READBACK_EN
        strobe(2'b11, 8'h00);
        check("read_ignored_busy", busy, 0);
        check("read_ignored_cursor", cursor, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
